aes256_unloading: RTL and testbench



---
 rtl/aes256_unloading.sv | 77 +++++++
 tb/tb_aes256_unloading.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/aes256_unloading.sv
// Collects the AES-256 ciphertext byte stream into 128-bit blocks and
// hands them downstream through a one-deep holding stage with valid/ack.
module aes256_unloading #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pi_byte_valid,
  input  logic [7:0]   pi_byte,
  input  logic         pi_clear,
  input  logic         pi_block_ack,
  output logic         po_block_valid,
  output logic [127:0] po_block,
  output logic [4:0]   po_byte_count,
  output logic         po_overflow
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} hold_st_t;

  logic [127:0] r_shift;
  logic [3:0]   r_cnt;
  logic [127:0] r_block;
  hold_st_t     r_st;
  logic         r_ovf;

  logic [127:0] w_shift;
  logic         w_complete;

  // The block completes on the byte that wraps the counter, so the
  // holding register loads the shifted value, not r_shift.
  assign w_shift    = MSB_FIRST ? {r_shift[119:0], pi_byte}
                                : {pi_byte, r_shift[127:8]};
  assign w_complete = pi_byte_valid && (r_cnt == 4'hf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_block <= '0;
      r_st    <= ST_EMPTY;
      r_ovf   <= 1'b0;
    end else if (pi_clear) begin
      r_cnt <= '0;
      r_st  <= ST_EMPTY;
      r_ovf <= 1'b0;
    end else begin
      if (pi_byte_valid) begin
        r_shift <= w_shift;
        r_cnt   <= r_cnt + 4'd1;
      end
      case (r_st)
        ST_EMPTY: begin
          if (w_complete) begin
            r_block <= w_shift;
            r_st    <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_complete && pi_block_ack) begin
            r_block <= w_shift;
          end else if (w_complete) begin
            r_ovf <= 1'b1;
          end else if (pi_block_ack) begin
            r_st <= ST_EMPTY;
          end
        end
        default: r_st <= ST_EMPTY;
      endcase
    end
  end

  assign po_block_valid = (r_st == ST_FULL);
  assign po_block       = r_block;
  assign po_byte_count  = {1'b0, r_cnt};
  assign po_overflow    = r_ovf;

endmodule

// File: tb/tb_aes256_unloading.sv
// Bench for aes256_unloading: both byte orders driven in parallel and
// compared every cycle against a queue-based model of the collector.
module tb_aes256_unloading;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pi_byte_valid = 1'b0;
  logic [7:0]   pi_byte = '0;
  logic         pi_clear = 1'b0;
  logic         pi_block_ack = 1'b0;
  logic         vld_m, vld_l;
  logic [127:0] blk_m, blk_l;
  logic [4:0]   cnt_m, cnt_l;
  logic         ovf_m, ovf_l;

  aes256_unloading #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .pi_byte_valid(pi_byte_valid), .pi_byte(pi_byte),
    .pi_clear(pi_clear), .pi_block_ack(pi_block_ack), .po_block_valid(vld_m),
    .po_block(blk_m), .po_byte_count(cnt_m), .po_overflow(ovf_m));

  aes256_unloading #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .pi_byte_valid(pi_byte_valid), .pi_byte(pi_byte),
    .pi_clear(pi_clear), .pi_block_ack(pi_block_ack), .po_block_valid(vld_l),
    .po_block(blk_l), .po_byte_count(cnt_l), .po_overflow(ovf_l));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // model state
  logic [7:0]   mq[$];
  bit           m_vld;
  logic [127:0] m_blk_m, m_blk_l;
  bit           m_ovf;

  task automatic model_reset();
    mq.delete();
    m_vld = 0; m_ovf = 0; m_blk_m = '0; m_blk_l = '0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] b, input bit clr, input bit ack);
    bit done;
    logic [127:0] bm, bl;
    done = 0; bm = '0; bl = '0;
    if (clr) begin
      mq.delete(); m_vld = 0; m_ovf = 0;
      return;
    end
    if (v) begin
      mq.push_back(b);
      if (mq.size() == 16) begin
        for (int i = 0; i < 16; i++) begin
          bm[127-8*i -: 8] = mq[i];
          bl[8*i +: 8]     = mq[i];
        end
        mq.delete();
        done = 1;
      end
    end
    if (done) begin
      if (!m_vld || ack) begin
        m_blk_m = bm; m_blk_l = bl; m_vld = 1;
      end else m_ovf = 1;
    end else if (ack) m_vld = 0;
  endtask

  task automatic check_all();
    chk("vld_msb", vld_m, m_vld);
    chk("vld_lsb", vld_l, m_vld);
    chk("cnt_msb", cnt_m, mq.size());
    chk("cnt_lsb", cnt_l, mq.size());
    chk("ovf_msb", ovf_m, m_ovf);
    chk("ovf_lsb", ovf_l, m_ovf);
    if (m_vld) begin
      chk("blk_msb", blk_m, m_blk_m);
      chk("blk_lsb", blk_l, m_blk_l);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vld"}, {vld_m, vld_l}, '0);
    chk({tag, "_blk_msb"}, blk_m, '0);
    chk({tag, "_blk_lsb"}, blk_l, '0);
    chk({tag, "_cnt"}, {cnt_m, cnt_l}, '0);
    chk({tag, "_ovf"}, {ovf_m, ovf_l}, '0);
  endtask

  task automatic step(input bit v, input logic [7:0] b, input bit clr, input bit ack);
    pi_byte_valid = v; pi_byte = b; pi_clear = clr; pi_block_ack = ack;
    @(posedge clk);
    model_edge(v, b, clr, ack);
    #1;
    check_all();
    pi_byte_valid = 0; pi_clear = 0; pi_block_ack = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
  endtask

  logic [7:0] vec[16];
  logic [127:0] vec_blk;

  initial begin
    vec = '{8'h8e, 8'ha2, 8'hb7, 8'hca, 8'h51, 8'h67, 8'h45, 8'hbf,
            8'hea, 8'hfc, 8'h49, 8'h90, 8'h4b, 8'h49, 8'h60, 8'h89};
    vec_blk = 128'h8ea2b7ca516745bfeafc49904b496089;
    model_reset();
    #12;
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // known vector, back to back
    for (int i = 0; i < 16; i++) step(1, vec[i], 0, 0);
    chk("vec_blk", blk_m, vec_blk);
    chk("vec_vld", vld_m, 1'b1);
    chk("vec_cnt", cnt_m, 5'd0);
    step(0, 8'h00, 0, 1);
    chk("ack_drop", vld_m, 1'b0);

    // same bytes with random gaps, ack two cycles after valid
    for (int i = 0; i < 16; i++) begin
      idle($urandom_range(0, 3));
      step(1, vec[i], 0, 0);
    end
    chk("gap_blk", blk_m, vec_blk);
    idle(1);
    step(0, 8'h00, 0, 1);
    chk("gap_ack_drop", vld_m, 1'b0);

    // two blocks, ack on the second block's last byte
    for (int i = 0; i < 16; i++) step(1, vec[i], 0, 0);
    for (int i = 0; i < 16; i++) step(1, 8'(i * 17 + 3), 0, i == 15);
    chk("b2b_vld", vld_m, 1'b1);
    chk("b2b_ovf", ovf_m, 1'b0);
    step(0, 8'h00, 0, 1);

    // two blocks, no ack: overflow, first block kept
    for (int i = 0; i < 16; i++) step(1, vec[i], 0, 0);
    for (int i = 0; i < 16; i++) step(1, 8'($urandom), 0, 0);
    chk("ovf_set", ovf_m, 1'b1);
    chk("ovf_keep", blk_m, vec_blk);
    idle(3);
    step(0, 8'h00, 1, 0);
    chk("clr_ovf", ovf_m, 1'b0);

    // clear together with the 8th byte
    for (int i = 0; i < 7; i++) step(1, 8'($urandom), 0, 0);
    step(1, 8'hff, 1, 0);
    chk("clr_cnt", cnt_m, 5'd0);
    for (int i = 0; i < 16; i++) step(1, vec[i], 0, 0);
    chk("clr_blk", blk_m, vec_blk);
    step(0, 8'h00, 0, 1);

    // async reset mid-cycle after 9 bytes
    for (int i = 0; i < 9; i++) step(1, 8'($urandom), 0, 0);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    chk("seq_msb", blk_m, 128'h000102030405060708090a0b0c0d0e0f);
    chk("seq_lsb", blk_l, 128'h0f0e0d0c0b0a09080706050403020100);

    // random soak
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 99) < 2,
           $urandom_range(0, 9) < 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
